// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Main control FSM for a multi-cycle MIPS datapath with a shared ALU and a
// shared instruction/data memory. Instructions go through fetch, decode,
// execute, memory and write-back steps, one instruction at a time.
// Supported instructions: R-type, lw, sw, beq, addi and j.
// Memory accesses stall on mem_ready. A counter tracks retired instructions.
//
// Ports
//   clk           system clock; all state changes on the rising edge
//   rst_n         synchronous active-low reset
//   opcode        instruction[31:26] from the instruction register
//   mem_ready     memory completed the current read/write this cycle
//   pc_write      unconditional PC load
//   pc_write_cond PC load qualified by ALU zero (beq)
//   iord          memory address select (0 = PC, 1 = ALUOut)
//   mem_read      memory read request
//   mem_write     memory write request
//   ir_write      instruction register load
//   mem_to_reg    write-back data select (1 = memory data register)
//   reg_dst       destination register select (1 = rd, 0 = rt)
//   reg_write     register file write enable
//   alu_src_a     ALU operand A select (0 = PC, 1 = register A)
//   alu_src_b     ALU operand B select (B / 4 / imm / imm<<2)
//   alu_op        ALU operation class (add / sub / funct / addi)
//   pc_source     PC source select (ALU / ALUOut / jump target)
//   state         current state encoding, for debug
//   instr_done    pulse on the last cycle of each retired instruction
//   illegal_op    pulse in DECODE for an unsupported opcode
//   instr_count   retired-instruction count, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic [3:0]       state,
   output logic             instr_done,
   output logic             illegal_op,
   output logic [CNT_W-1:0] instr_count
);

   localparam logic [3:0] S_FETCH     = 4'd0;
   localparam logic [3:0] S_DECODE    = 4'd1;
   localparam logic [3:0] S_MEM_ADDR  = 4'd2;
   localparam logic [3:0] S_MEM_RD    = 4'd3;
   localparam logic [3:0] S_MEM_WB    = 4'd4;
   localparam logic [3:0] S_MEM_WR    = 4'd5;
   localparam logic [3:0] S_R_EXEC    = 4'd6;
   localparam logic [3:0] S_R_WB      = 4'd7;
   localparam logic [3:0] S_BRANCH    = 4'd8;
   localparam logic [3:0] S_JUMP      = 4'd9;
   localparam logic [3:0] S_ADDI_EXEC = 4'd10;
   localparam logic [3:0] S_ADDI_WB   = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   logic [3:0]       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Ungated versions of the enables that reset must suppress
   logic pc_write_raw, pc_write_cond_raw, ir_write_raw, reg_write_raw;
   logic mem_write_raw, done_raw, illegal_raw;

   always_comb begin
      state_d           = state_q;
      pc_write_raw      = 1'b0;
      pc_write_cond_raw = 1'b0;
      ir_write_raw      = 1'b0;
      reg_write_raw     = 1'b0;
      mem_write_raw     = 1'b0;
      done_raw          = 1'b0;
      illegal_raw       = 1'b0;
      iord              = 1'b0;
      mem_read          = 1'b0;
      mem_to_reg        = 1'b0;
      reg_dst           = 1'b0;
      alu_src_a         = 1'b0;
      alu_src_b         = 2'b00;
      alu_op            = 2'b00;
      pc_source         = 2'b00;

      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            // IR and PC+4 are only committed once the fetch really completes
            if (mem_ready) begin
               ir_write_raw = 1'b1;
               pc_write_raw = 1'b1;
               state_d      = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               OP_RTYPE:     state_d = S_R_EXEC;
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDI_EXEC;
               OP_J:         state_d = S_JUMP;
               default: begin
                  illegal_raw = 1'b1;
                  state_d     = S_FETCH;
               end
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (mem_ready) state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            mem_to_reg    = 1'b1;
            reg_write_raw = 1'b1;
            done_raw      = 1'b1;
            state_d       = S_FETCH;
         end
         S_MEM_WR: begin
            mem_write_raw = 1'b1;
            iord          = 1'b1;
            if (mem_ready) begin
               done_raw = 1'b1;
               state_d  = S_FETCH;
            end
         end
         S_R_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_d   = S_R_WB;
         end
         S_R_WB: begin
            reg_dst       = 1'b1;
            reg_write_raw = 1'b1;
            done_raw      = 1'b1;
            state_d       = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a         = 1'b1;
            alu_op            = 2'b01;
            pc_write_cond_raw = 1'b1;
            pc_source         = 2'b01;
            done_raw          = 1'b1;
            state_d           = S_FETCH;
         end
         S_JUMP: begin
            pc_write_raw = 1'b1;
            pc_source    = 2'b10;
            done_raw     = 1'b1;
            state_d      = S_FETCH;
         end
         S_ADDI_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = 2'b11;
            state_d   = S_ADDI_WB;
         end
         S_ADDI_WB: begin
            reg_write_raw = 1'b1;
            done_raw      = 1'b1;
            state_d       = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_comb begin
      count_d = count_q;
      if (done_raw) count_d = count_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Architectural side effects are masked while reset is held, even when
   // reset lands in the middle of an instruction or a memory stall.
   assign pc_write      = pc_write_raw      & rst_n;
   assign pc_write_cond = pc_write_cond_raw & rst_n;
   assign ir_write      = ir_write_raw      & rst_n;
   assign reg_write     = reg_write_raw     & rst_n;
   assign mem_write     = mem_write_raw     & rst_n;
   assign instr_done    = done_raw          & rst_n;
   assign illegal_op    = illegal_raw       & rst_n;

   assign state       = state_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

   localparam int CNT_W = 4;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BAD  = 6'b111111;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [5:0]       opcode;
   logic             mem_ready;
   logic             pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic             mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0]       alu_src_b, alu_op, pc_source;
   logic [3:0]       state;
   logic             instr_done, illegal_op;
   logic [CNT_W-1:0] instr_count;

   mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .state(state), .instr_done(instr_done),
      .illegal_op(illegal_op), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   // One expected cycle: required state/pulses plus the inputs to drive
   typedef struct packed {
      logic [3:0] st;
      logic       done;
      logic       ill;
      logic       rdy;
      logic [5:0] op;
   } exp_t;

   exp_t             q[$];
   exp_t             e;
   int               total = 0;
   int               bad = 0;
   logic [CNT_W-1:0] exp_cnt;
   int               n_done, n_ill;

   // Expected per-cycle behaviour of one instruction, pushed as stimulus is planned.
   // mem_ready is randomised in states where it must be ignored.
   function automatic void push_instr(input logic [5:0] op, input int fst, input int mst);
      logic rx;
      for (int i = 0; i < fst; i++) q.push_back('{st:4'd0, done:1'b0, ill:1'b0, rdy:1'b0, op:op});
      q.push_back('{st:4'd0, done:1'b0, ill:1'b0, rdy:1'b1, op:op});
      rx = 1'($urandom_range(0, 1));
      case (op)
         OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J:
            q.push_back('{st:4'd1, done:1'b0, ill:1'b0, rdy:rx, op:op});
         default:
            q.push_back('{st:4'd1, done:1'b0, ill:1'b1, rdy:rx, op:op});
      endcase
      rx = 1'($urandom_range(0, 1));
      case (op)
         OP_R: begin
            q.push_back('{st:4'd6, done:1'b0, ill:1'b0, rdy:rx, op:op});
            q.push_back('{st:4'd7, done:1'b1, ill:1'b0, rdy:~rx, op:op});
         end
         OP_LW: begin
            q.push_back('{st:4'd2, done:1'b0, ill:1'b0, rdy:rx, op:op});
            for (int i = 0; i < mst; i++) q.push_back('{st:4'd3, done:1'b0, ill:1'b0, rdy:1'b0, op:op});
            q.push_back('{st:4'd3, done:1'b0, ill:1'b0, rdy:1'b1, op:op});
            q.push_back('{st:4'd4, done:1'b1, ill:1'b0, rdy:~rx, op:op});
         end
         OP_SW: begin
            q.push_back('{st:4'd2, done:1'b0, ill:1'b0, rdy:rx, op:op});
            for (int i = 0; i < mst; i++) q.push_back('{st:4'd5, done:1'b0, ill:1'b0, rdy:1'b0, op:op});
            q.push_back('{st:4'd5, done:1'b1, ill:1'b0, rdy:1'b1, op:op});
         end
         OP_BEQ:  q.push_back('{st:4'd8, done:1'b1, ill:1'b0, rdy:rx, op:op});
         OP_J:    q.push_back('{st:4'd9, done:1'b1, ill:1'b0, rdy:rx, op:op});
         OP_ADDI: begin
            q.push_back('{st:4'd10, done:1'b0, ill:1'b0, rdy:rx, op:op});
            q.push_back('{st:4'd11, done:1'b1, ill:1'b0, rdy:~rx, op:op});
         end
         default: ;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mem_ready = 1'b0;
      opcode = OP_R;
      tick();
      rst_n = 1'b1;
      exp_cnt = '0;
      n_done = 0;
      n_ill = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      mem_ready = 1'b1;
      opcode = OP_J;
      tick();
      tick();
      #4;
      total++; if (state !== 4'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
      total++; if (instr_count !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", instr_count); end
      total++; if ({pc_write, ir_write, instr_done, illegal_op} !== 4'b0) begin
         bad++; $display("FAIL reset_forced_low: got %b want 0000", {pc_write, ir_write, instr_done, illegal_op});
      end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset_midstall();
      do_reset();
      mem_ready = 1'b1;
      opcode = OP_J;
      tick(); tick(); tick();
      opcode = OP_SW;
      tick(); tick(); tick();
      mem_ready = 1'b0;
      #4;
      total++; if (state !== 4'd5 || mem_write !== 1'b1 || instr_count !== 4'd1) begin
         bad++; $display("FAIL midstall_pre: got st=%0d mw=%b cnt=%0d want st=5 mw=1 cnt=1", state, mem_write, instr_count);
      end
      tick();
      rst_n = 1'b0;
      #4;
      total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL midstall_mw_forced: got %b want 0", mem_write); end
      tick();
      rst_n = 1'b1;
      #4;
      total++; if (state !== 4'd0 || instr_count !== 4'd0 || mem_write !== 1'b0 || ir_write !== 1'b0) begin
         bad++; $display("FAIL midstall_after: got st=%0d cnt=%0d mw=%b ir=%b want 0 0 0 0", state, instr_count, mem_write, ir_write);
      end
      tick();
      mem_ready = 1'b1;
      #4;
      total++; if (state !== 4'd0 || ir_write !== 1'b1) begin
         bad++; $display("FAIL midstall_fetch_rdy: got st=%0d ir=%b want st=0 ir=1", state, ir_write);
      end
      tick();
      #4;
      total++; if (state !== 4'd1) begin bad++; $display("FAIL midstall_decode: got %0d want 1", state); end
   endtask

   task automatic test_sequence();
      do_reset();
      push_instr(OP_LW, 0, 0);
      push_instr(OP_SW, 0, 0);
      push_instr(OP_R, 0, 0);
      push_instr(OP_ADDI, 0, 0);
      push_instr(OP_BEQ, 0, 0);
      push_instr(OP_J, 0, 0);
      while (q.size() > 0) begin
         e = q.pop_front();
         opcode = e.op; mem_ready = e.rdy;
         #4;
         total++; if (state !== e.st) begin bad++; $display("FAIL seq_state: got %0d want %0d", state, e.st); end
         total++; if (instr_done !== e.done) begin bad++; $display("FAIL seq_done: got %b want %b st=%0d", instr_done, e.done, e.st); end
         total++; if (instr_count !== exp_cnt) begin bad++; $display("FAIL seq_count: got %0d want %0d", instr_count, exp_cnt); end
         if (instr_done === 1'b1) n_done++;
         if (e.done) exp_cnt++;
         tick();
      end
      #4;
      total++; if (state !== 4'd0) begin bad++; $display("FAIL seq_end_state: got %0d want 0", state); end
      total++; if (instr_count !== 4'd6) begin bad++; $display("FAIL seq_end_count: got %0d want 6", instr_count); end
      total++; if (n_done != 6) begin bad++; $display("FAIL seq_done_pulses: got %0d want 6", n_done); end
      tick();
   endtask

   task automatic test_mem_stall();
      do_reset();
      push_instr(OP_LW, 3, 2);
      while (q.size() > 0) begin
         e = q.pop_front();
         opcode = e.op; mem_ready = e.rdy;
         #4;
         total++; if (state !== e.st) begin bad++; $display("FAIL stall_state: got %0d want %0d", state, e.st); end
         total++; if (ir_write !== (e.st == 4'd0 && e.rdy)) begin
            bad++; $display("FAIL stall_ir_write: got %b want %b st=%0d", ir_write, (e.st == 4'd0 && e.rdy), e.st);
         end
         if (e.st == 4'd3) begin
            total++; if (mem_read !== 1'b1 || iord !== 1'b1) begin
               bad++; $display("FAIL stall_memrd_req: got rd=%b iord=%b want 1 1", mem_read, iord);
            end
         end
         total++; if (instr_done !== e.done) begin bad++; $display("FAIL stall_done: got %b want %b", instr_done, e.done); end
         tick();
      end
      #4;
      total++; if (state !== 4'd0 || instr_count !== 4'd1) begin
         bad++; $display("FAIL stall_end: got st=%0d cnt=%0d want 0 1", state, instr_count);
      end
      tick();
   endtask

   task automatic test_illegal();
      do_reset();
      push_instr(OP_J, 0, 0);
      push_instr(OP_BAD, 0, 0);
      push_instr(OP_J, 0, 0);
      exp_cnt = '0;
      while (q.size() > 0) begin
         e = q.pop_front();
         opcode = e.op; mem_ready = e.rdy;
         #4;
         total++; if (state !== e.st) begin bad++; $display("FAIL ill_state: got %0d want %0d", state, e.st); end
         total++; if (illegal_op !== e.ill) begin bad++; $display("FAIL ill_pulse: got %b want %b", illegal_op, e.ill); end
         total++; if (instr_done !== e.done) begin bad++; $display("FAIL ill_done: got %b want %b", instr_done, e.done); end
         total++; if (instr_count !== exp_cnt) begin bad++; $display("FAIL ill_count: got %0d want %0d", instr_count, exp_cnt); end
         if (illegal_op === 1'b1) n_ill++;
         if (e.done) exp_cnt++;
         tick();
      end
      total++; if (n_ill != 1) begin bad++; $display("FAIL ill_pulse_count: got %0d want 1", n_ill); end
   endtask

   task automatic test_decode_outputs();
      do_reset();
      push_instr(OP_ADDI, 0, 0);
      push_instr(OP_BEQ, 0, 0);
      while (q.size() > 0) begin
         e = q.pop_front();
         opcode = e.op; mem_ready = e.rdy;
         #4;
         total++; if (state !== e.st) begin bad++; $display("FAIL dec_state: got %0d want %0d", state, e.st); end
         if (e.st == 4'd1) begin
            total++; if ({pc_write, pc_write_cond, ir_write, reg_write, mem_write} !== 5'b0) begin
               bad++; $display("FAIL dec_writes: got %b want 00000", {pc_write, pc_write_cond, ir_write, reg_write, mem_write});
            end
            total++; if (alu_src_b !== 2'b11) begin bad++; $display("FAIL dec_srcb: got %b want 11", alu_src_b); end
         end
         if (e.st == 4'd10) begin
            total++; if ({alu_src_a, alu_src_b, alu_op} !== 5'b1_10_11) begin
               bad++; $display("FAIL addi_exec_out: got %b want 11011", {alu_src_a, alu_src_b, alu_op});
            end
         end
         if (e.st == 4'd11) begin
            total++; if ({reg_write, reg_dst, mem_to_reg} !== 3'b100) begin
               bad++; $display("FAIL addi_wb_out: got %b want 100", {reg_write, reg_dst, mem_to_reg});
            end
         end
         if (e.st == 4'd8) begin
            total++; if ({pc_write_cond, pc_source, alu_op, alu_src_a, pc_write} !== 7'b1_01_01_1_0) begin
               bad++; $display("FAIL branch_out: got %b want 1010110", {pc_write_cond, pc_source, alu_op, alu_src_a, pc_write});
            end
         end
         tick();
      end
   endtask

   task automatic test_count_wrap();
      do_reset();
      for (int i = 0; i < 17; i++) push_instr(OP_J, 0, 0);
      while (q.size() > 0) begin
         e = q.pop_front();
         opcode = e.op; mem_ready = e.rdy;
         #4;
         total++; if (instr_count !== exp_cnt) begin bad++; $display("FAIL wrap_count: got %0d want %0d", instr_count, exp_cnt); end
         if (e.done) exp_cnt++;
         tick();
      end
      #4;
      total++; if (instr_count !== 4'd1) begin bad++; $display("FAIL wrap_final: got %0d want 1", instr_count); end
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      mem_ready = 1'b0;
      opcode = OP_R;
      exp_cnt = '0;
      n_done = 0;
      n_ill = 0;
      tick();
      test_reset();
      test_reset_midstall();
      test_sequence();
      test_mem_stall();
      test_illegal();
      test_decode_outputs();
      test_count_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
